// File: rtl/candy_avb_pio_pulse_sequencer_pkg.sv
// Shared definitions for the Avalon-MM pulse sequencer:
// register map, CONTROL bit positions and sequencer states.
package candy_avb_pio_pulse_sequencer_pkg;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_CONTROL = 2'd1;
   localparam logic [1:0] REG_PULSE   = 2'd2;
   localparam logic [1:0] REG_HOLDOFF = 2'd3;

   localparam int CTRL_START  = 0;
   localparam int CTRL_IRQ_EN = 1;
   localparam int CTRL_DONE   = 2;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ASSERT  = 2'd1,
      S_HOLDOFF = 2'd2
   } state_t;

endpackage

// File: rtl/candy_avb_pio_pulse_sequencer_timer.sv
// Loadable down-counter for the pulse sequencer phases.
// Load wins over enable; the count holds once it reaches zero.
module candy_avb_pio_pulse_timer #(
   parameter int CNT_W = 24
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             load,
   input  logic             en,
   input  logic [CNT_W-1:0] load_val,
   output logic [CNT_W-1:0] cnt,
   output logic             zero
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && cnt != '0) begin
         cnt <= cnt - CNT_W'(1);
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/candy_avb_pio_pulse_sequencer.sv
// Avalon-MM slave that drives one control line directly or as a
// timed pulse followed by a hold-off, flagging DONE with optional irq.
module candy_avb_pio_pulse_sequencer
   import candy_avb_pio_pulse_sequencer_pkg::*;
#(
   parameter logic ASSERT_LEVEL = 1'b0,
   parameter logic RESET_VALUE  = 1'b1,
   parameter int   CNT_W        = 24
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  address,
   input  logic        chipselect,
   input  logic        write_n,
   input  logic        read_n,
   input  logic [31:0] writedata,
   output logic [31:0] readdata,
   output logic        out_port,
   output logic        irq
);

   state_t           state_q, state_d;
   logic             line_q, line_d;
   logic             irq_en_q;
   logic             done_q;
   logic             done_set;
   logic [CNT_W-1:0] pulse_q;
   logic [CNT_W-1:0] holdoff_q;
   logic             tmr_load;
   logic [CNT_W-1:0] tmr_val;
   logic [CNT_W-1:0] tmr_cnt;
   logic             tmr_zero;
   logic             wr;
   logic             wr_data;
   logic             wr_ctrl;
   logic             start;
   logic             done_clr;
   logic             busy;
   logic             unused_ok;

   assign wr       = chipselect && !write_n;
   assign wr_data  = wr && (address == REG_DATA);
   assign wr_ctrl  = wr && (address == REG_CONTROL);
   assign start    = wr_ctrl && writedata[CTRL_START];
   assign done_clr = wr_ctrl && writedata[CTRL_DONE];
   assign busy     = (state_q != S_IDLE);

   assign unused_ok = &{1'b0, read_n, writedata, tmr_cnt};

   candy_avb_pio_pulse_timer #(
      .CNT_W (CNT_W)
   ) u_timer (
      .clk      (clk),
      .reset_n  (reset_n),
      .load     (tmr_load),
      .en       (busy),
      .load_val (tmr_val),
      .cnt      (tmr_cnt),
      .zero     (tmr_zero)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         line_q  <= RESET_VALUE;
      end else begin
         state_q <= state_d;
         line_q  <= line_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      line_d   = line_q;
      done_set = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d  = S_ASSERT;
               line_d   = ASSERT_LEVEL;
               tmr_load = 1'b1;
               // zero width behaves as a one-cycle pulse
               if (pulse_q != '0) tmr_val = pulse_q - CNT_W'(1);
            end else if (wr_data) begin
               line_d = writedata[0];
            end
         end
         S_ASSERT: begin
            if (tmr_zero) begin
               line_d = ~ASSERT_LEVEL;
               if (holdoff_q != '0) begin
                  state_d  = S_HOLDOFF;
                  tmr_load = 1'b1;
                  tmr_val  = holdoff_q - CNT_W'(1);
               end else begin
                  state_d  = S_IDLE;
                  done_set = 1'b1;
               end
            end
         end
         S_HOLDOFF: begin
            if (tmr_zero) begin
               state_d  = S_IDLE;
               done_set = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         irq_en_q  <= 1'b0;
         done_q    <= 1'b0;
         pulse_q   <= CNT_W'(1);
         holdoff_q <= '0;
      end else begin
         if (wr_ctrl) irq_en_q <= writedata[CTRL_IRQ_EN];
         if (done_set) done_q <= 1'b1;
         else if (done_clr) done_q <= 1'b0;
         if (wr && address == REG_PULSE) pulse_q <= writedata[CNT_W-1:0];
         if (wr && address == REG_HOLDOFF) holdoff_q <= writedata[CNT_W-1:0];
      end
   end

   always_comb begin
      readdata = '0;
      unique case (address)
         REG_DATA:    readdata[0] = line_q;
         REG_CONTROL: begin
            readdata[CTRL_START]  = busy;
            readdata[CTRL_IRQ_EN] = irq_en_q;
            readdata[CTRL_DONE]   = done_q;
         end
         REG_PULSE:   readdata[CNT_W-1:0] = pulse_q;
         REG_HOLDOFF: readdata[CNT_W-1:0] = holdoff_q;
         default:     readdata = '0;
      endcase
   end

   assign out_port = line_q;
   assign irq      = done_q & irq_en_q;

endmodule

// File: tb/tb_candy_avb_pio_pulse_sequencer.sv
// Directed bench for the pulse sequencer: register reset values,
// manual drive, timed pulses, ignored writes while busy, async abort.
module tb_candy_avb_pio_pulse_sequencer;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [1:0]  address = '0;
   logic        chipselect = 1'b0;
   logic        write_n = 1'b1;
   logic        read_n = 1'b1;
   logic [31:0] writedata = '0;
   logic [31:0] readdata;
   logic        out_port;
   logic        irq;

   int checks = 0;
   int errors = 0;
   int low;

   candy_avb_pio_pulse_sequencer dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .read_n     (read_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      @(negedge clk);
      address    = a;
      writedata  = d;
      chipselect = 1'b1;
      write_n    = 1'b0;
      @(posedge clk);
      #1;
      chipselect = 1'b0;
      write_n    = 1'b1;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      address = a;
      read_n  = 1'b0;
      #1;
      d = readdata;
      read_n = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // counts further low cycles, sampling 1 after each edge
   task automatic count_low(inout int n);
      int guard;
      guard = 0;
      while (out_port == 1'b0 && guard < 200) begin
         step();
         if (out_port == 1'b0) n++;
         guard++;
      end
      if (guard >= 200) begin
         checks++;
         errors++;
         $error("FAIL pulse_timeout observed=%0d expected=<200", guard);
      end
   endtask

   logic [31:0] v;

   initial begin
      #22;
      reset_n = 1'b1;
      step();

      rd(2'd0, v); chk("rst_data", v, 32'd1);
      rd(2'd1, v); chk("rst_ctrl", v, 32'd0);
      rd(2'd2, v); chk("rst_pulse", v, 32'd1);
      rd(2'd3, v); chk("rst_holdoff", v, 32'd0);
      chk("rst_out", {31'd0, out_port}, 32'd1);
      chk("rst_irq", {31'd0, irq}, 32'd0);

      wr(2'd0, 32'd0);
      chk("man_out0", {31'd0, out_port}, 32'd0);
      rd(2'd0, v); chk("man_rd0", v, 32'd0);
      wr(2'd0, 32'd1);
      chk("man_out1", {31'd0, out_port}, 32'd1);
      rd(2'd0, v); chk("man_rd1", v, 32'd1);

      // 5-cycle pulse, 3-cycle hold-off, irq enabled
      wr(2'd2, 32'd5);
      wr(2'd3, 32'd3);
      wr(2'd1, 32'd3);
      low = (out_port == 1'b0) ? 1 : 0;
      rd(2'd1, v); chk("p5_busy0", v, 32'd3);
      count_low(low);
      chk("p5_width", low, 32'd5);
      step(); step();
      rd(2'd1, v); chk("p5_busy7", v, 32'd3);
      chk("p5_noirq7", {31'd0, irq}, 32'd0);
      step();
      rd(2'd1, v); chk("p5_done8", v, 32'd6);
      chk("p5_irq", {31'd0, irq}, 32'd1);
      chk("p5_out", {31'd0, out_port}, 32'd1);
      wr(2'd1, 32'd6);
      chk("p5_irqclr", {31'd0, irq}, 32'd0);
      rd(2'd1, v); chk("p5_ctrlclr", v, 32'd2);

      // zero width and zero hold-off: one-cycle pulse, DONE at its end
      wr(2'd2, 32'd0);
      wr(2'd3, 32'd0);
      wr(2'd1, 32'd3);
      chk("p0_low", {31'd0, out_port}, 32'd0);
      rd(2'd1, v); chk("p0_busy", v, 32'd3);
      step();
      chk("p0_high", {31'd0, out_port}, 32'd1);
      rd(2'd1, v); chk("p0_done", v, 32'd6);
      chk("p0_irq", {31'd0, irq}, 32'd1);
      wr(2'd1, 32'd6);
      rd(2'd1, v); chk("p0_clr", v, 32'd2);

      // DATA write and re-START during the pulse are ignored
      wr(2'd2, 32'd10);
      wr(2'd1, 32'd3);
      low = (out_port == 1'b0) ? 1 : 0;
      wr(2'd0, 32'd1);
      chk("p10_dataign", {31'd0, out_port}, 32'd0);
      if (out_port == 1'b0) low++;
      wr(2'd1, 32'd3);
      if (out_port == 1'b0) low++;
      count_low(low);
      chk("p10_width", low, 32'd10);
      rd(2'd1, v); chk("p10_done", v, 32'd6);
      rd(2'd0, v); chk("p10_data", v, 32'd1);
      step(); step();
      chk("p10_noext", {31'd0, out_port}, 32'd1);

      // asynchronous abort in the middle of a long pulse
      wr(2'd2, 32'd100);
      wr(2'd1, 32'd7);
      step(); step(); step();
      chk("ab_low", {31'd0, out_port}, 32'd0);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("ab_out", {31'd0, out_port}, 32'd1);
      chk("ab_irq", {31'd0, irq}, 32'd0);
      #10;
      reset_n = 1'b1;
      step();
      rd(2'd1, v); chk("ab_ctrl", v, 32'd0);
      rd(2'd2, v); chk("ab_pulse", v, 32'd1);
      step(); step();
      chk("ab_out2", {31'd0, out_port}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
